// File: rtl/instr_loader.sv
// Push-button front end: synchronizer, debouncer and rising-edge pulse, plus a
// two-press assembler that builds a 16-bit instruction from high and low switch bytes.
module instr_loader #(
    parameter int DB_CYCLES = 50000,
    parameter int CNT_W     = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        btn_raw,
    input  logic [7:0]  sw,
    input  logic        load_en,
    output logic        btn_edge,
    output logic [3:0]  opcode,
    output logic [11:0] instr,
    output logic        inst_done,
    output logic        byte_sel
);

    typedef enum logic [1:0] {
        S_HI   = 2'd0,
        S_LO   = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

    logic             sync_1;
    logic             btn_s;
    logic             btn_db;
    logic             db_prev;
    logic [CNT_W-1:0] db_cnt;
    logic [7:0]       hi_q;
    state_t           state;
    state_t           state_next;
    logic             finish_load;

    // Two-flop synchronizer; btn_raw is touched nowhere else.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_1 <= 1'b0;
            btn_s  <= 1'b0;
        end else begin
            sync_1 <= btn_raw;
            btn_s  <= sync_1;
        end
    end

    // The level flips only after DB_CYCLES consecutive mismatching samples.
    always_ff @(posedge clk) begin
        if (rst) begin
            btn_db <= 1'b0;
            db_cnt <= '0;
        end else if (btn_s == btn_db) begin
            db_cnt <= '0;
        end else if (db_cnt == CNT_LAST) begin
            btn_db <= btn_s;
            db_cnt <= '0;
        end else begin
            db_cnt <= db_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            db_prev  <= 1'b0;
            btn_edge <= 1'b0;
        end else begin
            db_prev  <= btn_db;
            btn_edge <= btn_db & ~db_prev;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_HI;
        end else begin
            state <= state_next;
        end
    end

    // Dropping load_en wins over everything, including a coincident low-byte press.
    always_comb begin
        state_next = state;
        case (state)
            S_HI:    if (btn_edge) state_next = S_LO;
            S_LO:    if (btn_edge) state_next = S_DONE;
            S_DONE:  state_next = S_HI;
            default: state_next = S_HI;
        endcase
        if (!load_en) state_next = S_HI;
    end

    assign finish_load = (state == S_LO) && load_en && btn_edge;
    assign byte_sel    = (state == S_LO);

    always_ff @(posedge clk) begin
        if (rst) begin
            hi_q <= '0;
        end else if (!load_en) begin
            hi_q <= '0;
        end else if (state == S_HI && btn_edge) begin
            hi_q <= sw;
        end
    end

    // Outputs change only when the low byte lands, so partial loads leave them intact.
    always_ff @(posedge clk) begin
        if (rst) begin
            opcode    <= '0;
            instr     <= '0;
            inst_done <= 1'b0;
        end else begin
            inst_done <= finish_load;
            if (finish_load) begin
                {opcode, instr} <= {hi_q, sw};
            end
        end
    end

endmodule

// File: tb/tb_instr_loader.sv
// Bench for instr_loader: press/debounce timing, table-driven instruction loads,
// abort and step-mode sequences, and reset during a partial load.
module tb_instr_loader;
    localparam int DB = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        btn_raw = 1'b0;
    logic [7:0]  sw = 8'h00;
    logic        load_en = 1'b0;
    logic        btn_edge;
    logic [3:0]  opcode;
    logic [11:0] instr;
    logic        inst_done;
    logic        byte_sel;

    instr_loader #(.DB_CYCLES(DB), .CNT_W(4)) dut (
        .clk(clk), .rst(rst), .btn_raw(btn_raw), .sw(sw), .load_en(load_en),
        .btn_edge(btn_edge), .opcode(opcode), .instr(instr),
        .inst_done(inst_done), .byte_sel(byte_sel)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int edge_cnt = 0;
    int done_cnt = 0;
    int last_edge_cyc = -1;
    int last_done_cyc = -1;
    logic prev_done = 1'b0;
    logic [15:0] exp_q[$];
    logic [15:0] last_word = 16'h0000;

    typedef struct {
        logic [7:0]  hi;
        logic [7:0]  lo;
        logic [7:0]  third;
        bit          abort;
        logic [15:0] exp_word;
    } vec_t;
    vec_t vecs[5];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // One clock step; outputs are sampled 1 time unit after the rising edge.
    task automatic step();
        logic [15:0] exp_word;
        @(posedge clk);
        #1;
        cyc++;
        if (btn_edge) begin
            edge_cnt++;
            last_edge_cyc = cyc;
        end
        if (inst_done) begin
            done_cnt++;
            last_done_cyc = cyc;
            check("done_single_cycle", 32'(prev_done), 32'd0);
            check("sb_pending", 32'(exp_q.size() > 0), 32'd1);
            if (exp_q.size() > 0) begin
                exp_word = exp_q.pop_front();
                check("sb_word", {16'h0, opcode, instr}, {16'h0, exp_word});
            end
        end
        prev_done = inst_done;
    endtask

    // Full press and release with a given switch byte; drop=1 lowers load_en
    // during the cycle that carries btn_edge.
    task automatic press(input logic [7:0] v, input bit exp_done, input bit drop);
        int start;
        int e0;
        int d0;
        sw = v;
        e0 = edge_cnt;
        d0 = done_cnt;
        btn_raw = 1'b1;
        start = cyc;
        repeat (DB + 6) begin
            step();
            if (drop && cyc == start + DB + 3) load_en = 1'b0;
        end
        if (drop) load_en = 1'b1;
        check("edge_count", 32'(edge_cnt - e0), 32'd1);
        check("edge_latency", 32'(last_edge_cyc - start), 32'(DB + 3));
        btn_raw = 1'b0;
        repeat (DB + 6) step();
        check("release_no_edge", 32'(edge_cnt - e0), 32'd1);
        check("done_count", 32'(done_cnt - d0), 32'(exp_done));
        if (exp_done) check("done_latency", 32'(last_done_cyc - start), 32'(DB + 4));
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_btn_edge"}, 32'(btn_edge), 32'd0);
        check({tag, "_opcode"}, 32'(opcode), 32'd0);
        check({tag, "_instr"}, 32'(instr), 32'd0);
        check({tag, "_inst_done"}, 32'(inst_done), 32'd0);
        check({tag, "_byte_sel"}, 32'(byte_sel), 32'd0);
    endtask

    initial begin
        int e0;
        int start;
        vecs[0] = '{hi: 8'hA5, lo: 8'h3C, third: 8'h00, abort: 1'b0, exp_word: 16'hA53C};
        vecs[1] = '{hi: 8'h12, lo: 8'h34, third: 8'h00, abort: 1'b0, exp_word: 16'h1234};
        vecs[2] = '{hi: 8'hFF, lo: 8'h00, third: 8'h00, abort: 1'b0, exp_word: 16'hFF00};
        vecs[3] = '{hi: 8'h00, lo: 8'hFF, third: 8'h00, abort: 1'b0, exp_word: 16'h00FF};
        vecs[4] = '{hi: 8'hA5, lo: 8'h11, third: 8'hC3, abort: 1'b1, exp_word: 16'h11C3};

        // Reset state.
        repeat (3) step();
        check_all_zero("reset");
        rst = 1'b0;
        step();

        // Short glitches and bouncing in step mode: no edges from any of it.
        e0 = edge_cnt;
        repeat (2) begin
            btn_raw = 1'b1;
            repeat (3) step();
            btn_raw = 1'b0;
            repeat (6) step();
        end
        check("glitch_no_edge", 32'(edge_cnt - e0), 32'd0);
        repeat (3) begin
            btn_raw = 1'b1;
            repeat (2) step();
            btn_raw = 1'b0;
            repeat (2) step();
        end
        check("bounce_no_edge", 32'(edge_cnt - e0), 32'd0);
        press(8'h00, 1'b0, 1'b0);

        // Table-driven loads.
        load_en = 1'b1;
        step();
        for (int i = 0; i < 5; i++) begin
            check("byte_sel_idle", 32'(byte_sel), 32'd0);
            press(vecs[i].hi, 1'b0, 1'b0);
            check("byte_sel_hi", 32'(byte_sel), 32'd1);
            check("hold_partial", {16'h0, opcode, instr}, {16'h0, last_word});
            if (vecs[i].abort) begin
                load_en = 1'b0;
                step();
                load_en = 1'b1;
                step();
                check("byte_sel_abort", 32'(byte_sel), 32'd0);
                press(vecs[i].lo, 1'b0, 1'b0);
                check("byte_sel_rehi", 32'(byte_sel), 32'd1);
                check("hold_abort", {16'h0, opcode, instr}, {16'h0, last_word});
                exp_q.push_back(vecs[i].exp_word);
                press(vecs[i].third, 1'b1, 1'b0);
            end else begin
                exp_q.push_back(vecs[i].exp_word);
                press(vecs[i].lo, 1'b1, 1'b0);
            end
            check("byte_sel_done", 32'(byte_sel), 32'd0);
            check("word_out", {16'h0, opcode, instr}, {16'h0, vecs[i].exp_word});
            last_word = vecs[i].exp_word;
        end

        // load_en falling in the same cycle as the low-byte edge aborts the load.
        press(8'h77, 1'b0, 1'b0);
        check("same_cycle_sel_hi", 32'(byte_sel), 32'd1);
        press(8'h88, 1'b0, 1'b1);
        check("same_cycle_sel", 32'(byte_sel), 32'd0);
        check("same_cycle_hold", {16'h0, opcode, instr}, {16'h0, last_word});

        // Step mode: edges only.
        load_en = 1'b0;
        e0 = edge_cnt;
        for (int i = 0; i < 3; i++) begin
            press(8'($urandom_range(0, 255)), 1'b0, 1'b0);
            check("step_byte_sel", 32'(byte_sel), 32'd0);
        end
        check("step_edges", 32'(edge_cnt - e0), 32'd3);

        // Reset in the middle of a load with the button held.
        load_en = 1'b1;
        step();
        press(8'h5A, 1'b0, 1'b0);
        check("pre_reset_sel", 32'(byte_sel), 32'd1);
        btn_raw = 1'b1;
        repeat (3) step();
        rst = 1'b1;
        step();
        check_all_zero("midload_reset");
        step();
        rst = 1'b0;
        e0 = edge_cnt;
        start = cyc;
        repeat (DB + 6) step();
        check("post_reset_edges", 32'(edge_cnt - e0), 32'd1);
        check("post_reset_latency", 32'(last_edge_cyc - start), 32'(DB + 3));
        btn_raw = 1'b0;
        repeat (DB + 6) step();
        check("post_reset_word", {16'h0, opcode, instr}, 32'd0);
        check("sb_drained", 32'(exp_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
